// File: rtl/alu_8bit_response_checker_if.sv
// Stimulus/response bundle between the ALU driver and the response checker.
// The master applies a vector and presents the ALU's response; the checker observes both.
interface alu_8bit_response_checker_if;
  logic       in_valid;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic [1:0] in_op;
  logic [7:0] dut_result;
  logic       dut_carry;
  logic       dut_zero;
  logic       dut_overflow;

  modport master (
    output in_valid, in_a, in_b, in_op,
    output dut_result, dut_carry, dut_zero, dut_overflow
  );

  modport slave (
    input in_valid, in_a, in_b, in_op,
    input dut_result, dut_carry, dut_zero, dut_overflow
  );
endinterface

// File: rtl/alu_8bit_response_checker.sv
// Response checker for the 8-bit ALU: golden model through a latency-matched delay line,
// saturating check/fail counters, first-failure capture and a sticky threshold alarm.
module alu_8bit_response_checker #(
  parameter int DUT_LATENCY  = 1,
  parameter int ALARM_THRESH = 1,
  parameter int CNT_W        = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic                       clear,
  alu_8bit_response_checker_if.slave vec,
  output logic [CNT_W-1:0]           check_count,
  output logic [CNT_W-1:0]           fail_count,
  output logic                       alarm,
  output logic                       fail_valid,
  output logic [7:0]                 fail_a,
  output logic [7:0]                 fail_b,
  output logic [1:0]                 fail_op,
  output logic [10:0]                fail_got,
  output logic [10:0]                fail_exp
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] THRESH  = CNT_W'(ALARM_THRESH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_ALARM = 2'b10
  } state_t;

  typedef struct packed {
    logic        valid;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [1:0]  op;
    logic [10:0] exp;
  } entry_t;

  // Expected response packed as {result, carry, zero, overflow}; carry is borrow on sub.
  function automatic logic [10:0] golden(input logic [7:0] a, input logic [7:0] b,
                                         input logic [1:0] op);
    logic [8:0] r;
    logic       c;
    logic       v;
    r = 9'h000;
    c = 1'b0;
    v = 1'b0;
    case (op)
      2'b00: begin
        r = {1'b0, a} + {1'b0, b};
        c = r[8];
        v = (a[7] == b[7]) && (r[7] != a[7]);
      end
      2'b01: begin
        r = {1'b0, a} - {1'b0, b};
        c = r[8];
        v = (a[7] != b[7]) && (r[7] != a[7]);
      end
      2'b10:   r = {1'b0, a & b};
      2'b11:   r = {1'b0, a | b};
      default: r = 9'h000;
    endcase
    return {r[7:0], c, (r[7:0] == 8'h00), v};
  endfunction

  state_t            state_r;
  state_t            state_next_s;
  entry_t            entry_s;
  entry_t            exit_s;
  logic              cmp_s;
  logic              miss_s;
  logic              hit_s;
  logic [10:0]       got_s;
  logic [CNT_W-1:0]  check_inc_s;
  logic [CNT_W-1:0]  fail_inc_s;
  logic [CNT_W-1:0]  check_r;
  logic [CNT_W-1:0]  fail_r;
  logic              alarm_r;
  logic              fail_valid_r;
  logic [7:0]        fail_a_r;
  logic [7:0]        fail_b_r;
  logic [1:0]        fail_op_r;
  logic [10:0]       fail_got_r;
  logic [10:0]       fail_exp_r;

  // Qualify the applied vector and attach its expected response
  always_comb begin
    entry_s.valid = vec.in_valid & enable & ~clear;
    entry_s.a     = vec.in_a;
    entry_s.b     = vec.in_b;
    entry_s.op    = vec.in_op;
    entry_s.exp   = golden(vec.in_a, vec.in_b, vec.in_op);
  end

  generate
    if (DUT_LATENCY == 0) begin : g_bypass
      assign exit_s = entry_s;
    end else begin : g_pipe
      entry_t stage_r [DUT_LATENCY];

      // Free-running delay line; clear flushes everything in flight
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DUT_LATENCY; i++) stage_r[i] <= '0;
        end else if (clear) begin
          for (int i = 0; i < DUT_LATENCY; i++) stage_r[i] <= '0;
        end else begin
          stage_r[0] <= entry_s;
          for (int i = 1; i < DUT_LATENCY; i++) stage_r[i] <= stage_r[i-1];
        end
      end

      assign exit_s = stage_r[DUT_LATENCY-1];
    end
  endgenerate

  // Compare at the delay-line exit and form the saturating counter updates
  always_comb begin
    got_s  = {vec.dut_result, vec.dut_carry, vec.dut_zero, vec.dut_overflow};
    cmp_s  = exit_s.valid & ~clear;
    miss_s = cmp_s & (got_s != exit_s.exp);
    if (check_r == CNT_MAX) begin
      check_inc_s = CNT_MAX;
    end else begin
      check_inc_s = check_r + CNT_ONE;
    end
    if (fail_r == CNT_MAX) begin
      fail_inc_s = CNT_MAX;
    end else begin
      fail_inc_s = fail_r + CNT_ONE;
    end
    hit_s = miss_s & (fail_inc_s >= THRESH);
  end

  // Next-state logic: clear is the only way out of ALARM
  always_comb begin
    state_next_s = state_r;
    if (clear) begin
      state_next_s = enable ? ST_RUN : ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE, ST_RUN: state_next_s = hit_s ? ST_ALARM : (enable ? ST_RUN : ST_IDLE);
        ST_ALARM:        state_next_s = ST_ALARM;
        default:         state_next_s = ST_IDLE;
      endcase
    end
  end

  // State register with alarm registered alongside it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      alarm_r <= 1'b0;
    end else begin
      state_r <= state_next_s;
      alarm_r <= (state_next_s == ST_ALARM);
    end
  end

  // Counters and first-failure capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      check_r      <= {CNT_W{1'b0}};
      fail_r       <= {CNT_W{1'b0}};
      fail_valid_r <= 1'b0;
      fail_a_r     <= 8'h00;
      fail_b_r     <= 8'h00;
      fail_op_r    <= 2'b00;
      fail_got_r   <= 11'h000;
      fail_exp_r   <= 11'h000;
    end else if (clear) begin
      check_r      <= {CNT_W{1'b0}};
      fail_r       <= {CNT_W{1'b0}};
      fail_valid_r <= 1'b0;
      fail_a_r     <= 8'h00;
      fail_b_r     <= 8'h00;
      fail_op_r    <= 2'b00;
      fail_got_r   <= 11'h000;
      fail_exp_r   <= 11'h000;
    end else begin
      if (cmp_s) check_r <= check_inc_s;
      if (miss_s) fail_r <= fail_inc_s;
      if (miss_s && !fail_valid_r) begin
        fail_valid_r <= 1'b1;
        fail_a_r     <= exit_s.a;
        fail_b_r     <= exit_s.b;
        fail_op_r    <= exit_s.op;
        fail_got_r   <= got_s;
        fail_exp_r   <= exit_s.exp;
      end
    end
  end

  assign check_count = check_r;
  assign fail_count  = fail_r;
  assign alarm       = alarm_r;
  assign fail_valid  = fail_valid_r;
  assign fail_a      = fail_a_r;
  assign fail_b      = fail_b_r;
  assign fail_op     = fail_op_r;
  assign fail_got    = fail_got_r;
  assign fail_exp    = fail_exp_r;

endmodule

// File: tb/tb_alu_8bit_response_checker.sv
// Bench for alu_8bit_response_checker: three configurations share one vector stream,
// each fed by an emulated ALU of matching latency with per-vector fault masks.
module tb_alu_8bit_response_checker;
  localparam int NI   = 3;
  localparam int HMAX = 4096;

  logic clk = 1'b0;
  logic rst_n;
  logic enable;
  logic clear;

  always #5 clk = ~clk;

  alu_8bit_response_checker_if if0();
  alu_8bit_response_checker_if if1();
  alu_8bit_response_checker_if if2();

  logic [15:0] chk0, fail0;
  logic [3:0]  chk1, fail1;
  logic [7:0]  chk2, fail2;
  logic        al0, al1, al2, fv0, fv1, fv2;
  logic [7:0]  fa0, fa1, fa2, fb0, fb1, fb2;
  logic [1:0]  fop0, fop1, fop2;
  logic [10:0] fgot0, fgot1, fgot2, fexp0, fexp1, fexp2;

  alu_8bit_response_checker #(.DUT_LATENCY(1), .ALARM_THRESH(1), .CNT_W(16)) u0 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear), .vec(if0),
    .check_count(chk0), .fail_count(fail0), .alarm(al0), .fail_valid(fv0),
    .fail_a(fa0), .fail_b(fb0), .fail_op(fop0), .fail_got(fgot0), .fail_exp(fexp0));

  alu_8bit_response_checker #(.DUT_LATENCY(3), .ALARM_THRESH(3), .CNT_W(4)) u1 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear), .vec(if1),
    .check_count(chk1), .fail_count(fail1), .alarm(al1), .fail_valid(fv1),
    .fail_a(fa1), .fail_b(fb1), .fail_op(fop1), .fail_got(fgot1), .fail_exp(fexp1));

  alu_8bit_response_checker #(.DUT_LATENCY(0), .ALARM_THRESH(2), .CNT_W(8)) u2 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear), .vec(if2),
    .check_count(chk2), .fail_count(fail2), .alarm(al2), .fail_valid(fv2),
    .fail_a(fa2), .fail_b(fb2), .fail_op(fop2), .fail_got(fgot2), .fail_exp(fexp2));

  // Per-cycle history of what was applied, and whether it is still awaiting comparison.
  logic        hv    [HMAX];
  logic [7:0]  ha    [HMAX];
  logic [7:0]  hb    [HMAX];
  logic [1:0]  hop   [HMAX];
  logic [10:0] hexp  [HMAX];
  logic [10:0] hresp [HMAX];
  int cyc;
  int checks;
  int errors;

  int          m_chk  [NI];
  int          m_fail [NI];
  logic        m_al   [NI];
  logic        m_fv   [NI];
  logic [39:0] m_cap  [NI];

  function automatic int lat_of(input int k);
    case (k)
      0:       return 1;
      1:       return 3;
      default: return 0;
    endcase
  endfunction

  function automatic int thr_of(input int k);
    case (k)
      0:       return 1;
      1:       return 3;
      default: return 2;
    endcase
  endfunction

  function automatic int max_of(input int k);
    case (k)
      0:       return 65535;
      1:       return 15;
      default: return 255;
    endcase
  endfunction

  // Reference ALU from integer arithmetic: overflow means the signed result leaves -128..127.
  function automatic logic [10:0] ref_alu(input logic [7:0] a, input logic [7:0] b,
                                          input logic [1:0] op);
    int ua, ub, sa, sb, r, s;
    logic c, v;
    logic [7:0] r8;
    ua = int'(a); ub = int'(b);
    sa = (ua > 127) ? ua - 256 : ua;
    sb = (ub > 127) ? ub - 256 : ub;
    c = 1'b0; v = 1'b0;
    case (op)
      2'd0: begin r = ua + ub; c = (r > 255); s = sa + sb; v = (s > 127) || (s < -128); end
      2'd1: begin r = ua - ub; c = (ua < ub); s = sa - sb; v = (s > 127) || (s < -128); end
      2'd2: r = ua & ub;
      default: r = ua | ub;
    endcase
    r8 = r[7:0];
    return {r8, c, (r8 == 8'h00), v};
  endfunction

  function automatic logic [10:0] resp_for(input int k);
    int idx;
    idx = cyc - lat_of(k);
    if (idx >= 0) return hresp[idx];
    return 11'($urandom);
  endfunction

  task automatic check(input string tag, input int k, input logic [63:0] obs,
                       input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s u%0d cyc=%0d observed=%0h expected=%0h", tag, k, cyc, obs, expv);
    end
  endtask

  task automatic check_k(input int k, input logic [15:0] c, input logic [15:0] f,
                         input logic al, input logic fv, input logic [39:0] cap);
    check("check_count", k, 64'(c), 64'(m_chk[k]));
    check("fail_count", k, 64'(f), 64'(m_fail[k]));
    check("alarm", k, 64'(al), 64'(m_al[k]));
    check("fail_valid", k, 64'(fv), 64'(m_fv[k]));
    check("capture", k, 64'(cap), 64'(m_cap[k]));
  endtask

  task automatic check_all();
    check_k(0, chk0, fail0, al0, fv0, {fa0, fb0, fop0, fgot0, fexp0});
    check_k(1, 16'(chk1), 16'(fail1), al1, fv1, {fa1, fb1, fop1, fgot1, fexp1});
    check_k(2, 16'(chk2), 16'(fail2), al2, fv2, {fa2, fb2, fop2, fgot2, fexp2});
  endtask

  task automatic model_clear(input int k);
    m_chk[k] = 0; m_fail[k] = 0; m_al[k] = 1'b0; m_fv[k] = 1'b0; m_cap[k] = 40'h0;
  endtask

  task automatic model_update(input int k, input logic clr);
    int idx;
    idx = cyc - lat_of(k);
    if (clr) begin
      model_clear(k);
    end else if (idx >= 0 && hv[idx]) begin
      m_chk[k] = (m_chk[k] + 1 > max_of(k)) ? max_of(k) : m_chk[k] + 1;
      if (hresp[idx] !== hexp[idx]) begin
        m_fail[k] = (m_fail[k] + 1 > max_of(k)) ? max_of(k) : m_fail[k] + 1;
        if (!m_fv[k]) begin
          m_fv[k]  = 1'b1;
          m_cap[k] = {ha[idx], hb[idx], hop[idx], hresp[idx], hexp[idx]};
        end
        if (m_fail[k] >= thr_of(k)) m_al[k] = 1'b1;
      end
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b,
                       input logic [1:0] op);
    logic [10:0] r;
    if0.in_valid = v; if0.in_a = a; if0.in_b = b; if0.in_op = op;
    if1.in_valid = v; if1.in_a = a; if1.in_b = b; if1.in_op = op;
    if2.in_valid = v; if2.in_a = a; if2.in_b = b; if2.in_op = op;
    r = resp_for(0);
    {if0.dut_result, if0.dut_carry, if0.dut_zero, if0.dut_overflow} = r;
    r = resp_for(1);
    {if1.dut_result, if1.dut_carry, if1.dut_zero, if1.dut_overflow} = r;
    r = resp_for(2);
    {if2.dut_result, if2.dut_carry, if2.dut_zero, if2.dut_overflow} = r;
  endtask

  task automatic record(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                        input logic [10:0] flt, input logic acc, input logic flush);
    ha[cyc] = a; hb[cyc] = b; hop[cyc] = op;
    hexp[cyc]  = ref_alu(a, b, op);
    hresp[cyc] = hexp[cyc] ^ flt;
    hv[cyc]    = acc;
    if (flush) begin
      for (int j = cyc - 4; j < cyc; j++) if (j >= 0) hv[j] = 1'b0;
    end
  endtask

  task automatic step(input logic v, input logic [7:0] a, input logic [7:0] b,
                      input logic [1:0] op, input logic [10:0] flt, input logic clr);
    clear = clr;
    record(a, b, op, flt, v & enable & ~clr, clr);
    drive(v, a, b, op);
    @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) model_update(k, clr);
    cyc++;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'($urandom), 8'($urandom), 2'($urandom), 11'h000, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear = 1'b0;
    record(8'h00, 8'h00, 2'b00, 11'h000, 1'b0, 1'b1);
    drive(1'b0, 8'h00, 8'h00, 2'b00);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < NI; k++) model_clear(k);
    cyc++;
    check_all();
  endtask

  initial begin
    logic [10:0] flt;
    checks = 0; errors = 0; cyc = 0;
    rst_n = 1'b0; enable = 1'b0; clear = 1'b0;
    for (int j = 0; j < HMAX; j++) hv[j] = 1'b0;
    for (int k = 0; k < NI; k++) model_clear(k);
    drive(1'b0, 8'h00, 8'h00, 2'b00);
    #12;
    do_reset();
    check("reset.check_count", 0, 64'(chk0), 64'd0);
    check("reset.alarm", 0, 64'(al0), 64'd0);

    // Add sweep
    enable = 1'b1;
    step(1'b1, 8'hFF, 8'hFF, 2'b00, 11'h000, 1'b0);
    step(1'b1, 8'h00, 8'h00, 2'b00, 11'h000, 1'b0);
    step(1'b1, 8'h7F, 8'h01, 2'b00, 11'h000, 1'b0);
    idle(4);
    check("add.check_count", 0, 64'(chk0), 64'd3);
    check("add.fail_count", 0, 64'(fail0), 64'd0);
    check("add.alarm", 0, 64'(al0), 64'd0);

    // Sub and logic ops
    step(1'b1, 8'hFF, 8'h01, 2'b01, 11'h000, 1'b0);
    step(1'b1, 8'h00, 8'h01, 2'b01, 11'h000, 1'b0);
    step(1'b1, 8'hAA, 8'h55, 2'b10, 11'h000, 1'b0);
    step(1'b1, 8'hAA, 8'h55, 2'b11, 11'h000, 1'b0);
    idle(4);
    check("sublogic.check_count", 1, 64'(chk1), 64'd7);
    check("sublogic.fail_count", 1, 64'(fail1), 64'd0);

    // Result bit 0 flipped on AA&55
    step(1'b1, 8'hAA, 8'h55, 2'b10, 11'h00A, 1'b0);
    idle(4);
    check("fault.fail_count", 0, 64'(fail0), 64'd1);
    check("fault.alarm", 0, 64'(al0), 64'd1);
    check("fault.capture", 0, 64'({fa0, fb0, fop0, fgot0, fexp0}),
          64'({8'hAA, 8'h55, 2'b10, 11'h008, 11'h002}));
    check("fault.alarm_below_thresh", 1, 64'(al1), 64'd0);

    // Two faulted vectors after clear: the capture keeps the first
    step(1'b1, 8'h99, 8'h99, 2'b00, 11'h000, 1'b1);
    step(1'b1, 8'h11, 8'h22, 2'b00, 11'h001, 1'b0);
    step(1'b1, 8'h33, 8'h44, 2'b01, 11'h100, 1'b0);
    idle(4);
    check("hold.fail_count", 0, 64'(fail0), 64'd2);
    check("hold.fail_a", 0, 64'(fa0), 64'h11);
    check("hold.alarm", 2, 64'(al2), 64'd1);

    // Saturation of the 4-bit counters
    step(1'b0, 8'h00, 8'h00, 2'b00, 11'h000, 1'b1);
    for (int i = 0; i < 20; i++)
      step(1'b1, 8'($urandom), 8'($urandom), 2'($urandom), 11'($urandom_range(1, 2047)), 1'b0);
    idle(4);
    check("sat.fail_count", 1, 64'(fail1), 64'd15);
    check("sat.alarm", 1, 64'(al1), 64'd1);
    check("sat.wide_fail_count", 0, 64'(fail0), 64'd20);

    // Clear with three vectors in flight
    step(1'b0, 8'h00, 8'h00, 2'b00, 11'h000, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 8'($urandom), 8'($urandom), 2'($urandom), 11'h7FF, 1'b0);
    step(1'b1, 8'h01, 8'h02, 2'b00, 11'h001, 1'b1);
    idle(4);
    check("clear.check_count", 1, 64'(chk1), 64'd0);
    check("clear.fail_count", 1, 64'(fail1), 64'd0);

    // Enable drops: accepted vectors still complete
    for (int i = 0; i < 3; i++) step(1'b1, 8'($urandom), 8'($urandom), 2'($urandom), 11'h000, 1'b0);
    enable = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b1, 8'($urandom), 8'($urandom), 2'($urandom), 11'h004, 1'b0);
    check("enable.check_count", 1, 64'(chk1), 64'd3);
    check("enable.fail_count", 1, 64'(fail1), 64'd0);

    // Reset with three vectors in flight
    enable = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b1, 8'($urandom), 8'($urandom), 2'($urandom), 11'h010, 1'b0);
    do_reset();
    idle(4);
    check("rst.check_count", 1, 64'(chk1), 64'd0);
    check("rst.fail_valid", 1, 64'(fv1), 64'd0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      enable = ($urandom_range(0, 9) != 0);
      flt = ($urandom_range(0, 9) == 0) ? 11'($urandom_range(1, 2047)) : 11'h000;
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom), 2'($urandom), flt,
             $urandom_range(0, 49) == 0);
      end
    end
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_8bit_response_checker.md
# alu_8bit_response_checker

Self-checking response monitor for the 8-bit ALU: it is the receiving end of the ALU stimulus interface. It samples each applied vector (A, B, op) and holds a golden model of the ALU through a delay line that matches the DUT's latency. It then compares the DUT's result and flags against the model and counts checks and mismatches. On a threshold it raises a sticky alarm and captures the first failing vector, so the same bench or an on-chip wrapper can flag Trojan-induced deviations.

## Interface
- `DUT_LATENCY`, 1, cycles from vector applied to DUT outputs valid; legal 0–4
- `ALARM_THRESH`, 1, mismatch count that raises `alarm`; legal 1..2^CNT_W-1
- `CNT_W`, 16, width of the check and mismatch counters
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `enable`  in  1  accept new vectors when high
- `clear`  in  1  synchronous clear of counters, pipeline, capture and alarm
- `in_valid`  in  1  vector on `in_a`/`in_b`/`in_op` is applied to the DUT this cycle
- `in_a`, `in_b`  in  8 each  operands
- `in_op`  in  2  00 add, 01 sub, 10 AND, 11 OR
- `dut_result`  in  8  DUT result
- `dut_carry`, `dut_zero`, `dut_overflow`  in  1 each  DUT flags
- `check_count`  out  CNT_W  vectors compared
- `fail_count`  out  CNT_W  vectors mismatched
- `alarm`  out  1  sticky; high once `fail_count` reaches `ALARM_THRESH`
- `fail_valid`  out  1  the first-failure capture below holds data
- `fail_a`, `fail_b`  out  8  operands of the first failing vector
- `fail_op`  out  2  op of the first failing vector
- `fail_got`  out  11  DUT response of the first failure: {result, carry, zero, overflow}
- `fail_exp`  out  11  expected response, same packing

## Operation
- Golden model, 9-bit arithmetic:
  - add: `r = A+B`; carry = bit 8; overflow = (A[7]==B[7]) && (r[7]!=A[7])
  - sub: `r = A-B`; carry = borrow = (A < B unsigned); overflow = (A[7]!=B[7]) && (r[7]!=A[7])
  - AND/OR: carry = 0, overflow = 0
  - all ops: zero = (r[7:0] == 0)
- Entry qualifier: `acc = in_valid & enable & ~clear`.
- Delay line: `DUT_LATENCY` register stages carry {valid, A, B, op, expected 11 bits}.
  - With latency 0 the comparison uses the live inputs.
  - All stages advance every cycle; there is no stall.
- Compare point: at the delay-line exit, if valid, compare all 11 bits.
  - `check_count` increments on every compare.
  - `fail_count` increments on any bit difference.
  - Both counters saturate at 2^CNT_W-1 and never wrap.
- First-failure capture: loads only when `fail_valid` is 0. It then holds until `clear` or reset.
- FSM states:
  - IDLE: `enable` = 0. No new entries; in-flight vectors are still compared.
  - RUN: `enable` = 1. Entries accepted.
  - ALARM: entered from IDLE or RUN when the incremented `fail_count` ≥ `ALARM_THRESH`. Sticky. Entries and compares continue per `enable`.
  - IDLE↔RUN follows `enable`.
  - ALARM exits only on `clear`, to RUN if `enable` else IDLE.
- `alarm` is high exactly in ALARM.
- `clear` has priority over `in_valid` and over a same-cycle compare: that vector is dropped, not counted, and the delay line is flushed.

## Timing
- Vector with `in_valid` in cycle n: DUT response sampled in cycle n+DUT_LATENCY.
- Counters, capture, `fail_valid` and `alarm` update on the edge ending that cycle, so they are visible in cycle n+DUT_LATENCY+1.
- Back-to-back vectors are accepted every cycle, with throughput 1 per cycle.
- Reset (asynchronous assert, synchronous deassert by the system): all counters 0, delay-line valids 0, `fail_*` 0, `fail_valid` 0, `alarm` 0, state IDLE.
- Reset mid-stream discards in-flight vectors. The first post-reset compare is for a vector accepted after reset.
- `enable` falling mid-stream: vectors already accepted still complete comparison, for up to DUT_LATENCY cycles.
- Simultaneous compare-fail and reaching the threshold: capture and `alarm` assert on the same edge.

## Test plan
- Add sweep, DUT_LATENCY=1, correct DUT model: FF+FF gives FE with carry 1, zero 0, ovf 0; 00+00 gives 00 with zero 1; 7F+01 gives 80 with ovf 1. Required: `check_count`=3, `fail_count`=0, `alarm`=0.
- Sub/logic: FF-01 gives FE with carry 0; 00-01 gives FF with carry 1; AA&55 gives 00 with zero 1; AA|55 gives FF. No failures.
- Fault injection, THRESH=1: `dut_result` bit 0 inverted on AA&55 (got 01, zero 0). Required one cycle after the compare: `fail_count`=1, `alarm`=1, `fail_a`=AA, `fail_b`=55, `fail_op`=10, `fail_got`=0x008, `fail_exp`=0x002.
- First-capture hold: two faulted vectors in a row. `fail_count`=2 and the capture shows the first vector only.
- Saturation, CNT_W=4: 20 faulted vectors, THRESH=3. `fail_count` sticks at 15, and `alarm` asserts at the third failure.
- Clear/reset mid-flight: with DUT_LATENCY=3 and 3 vectors in flight, pulse `clear`. No compare follows and the counters read 0. Repeat with `rst_n` low for 1 cycle: all outputs 0 and state IDLE.
